// File: rtl/tp_pkg.sv
// Shared constants, state/entry types and the bus byte-swap helper for the
// TestPort writer and its input FIFO.
package tp_pkg;

  localparam logic [29:0] TP_TEST_PORT  = 30'h0000_00FF;
  localparam logic [31:0] TP_BEGIN_SYM  = 32'h0000_0168;
  localparam logic [31:0] TP_END_SYM    = 32'hFFFF_FD5D;
  localparam int          TP_MAX_WORDS  = 32;
  localparam int          TP_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEGIN,
    GAP,
    WR_DATA,
    WR_END,
    DONE
  } tpw_state_t;

  typedef enum logic {
    KIND_DATA,
    KIND_END
  } tpw_kind_t;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } tpw_entry_t;

  // Readable (big-endian) word to little-endian bus order.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/tpw_fifo.sv
// Small synchronous FIFO of payload entries (word + last flag); pointers carry
// an extra wrap bit so full and empty are distinguishable.
module tpw_fifo
  import tp_pkg::*;
#(
  parameter int DEPTH = TP_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  tpw_entry_t wr_entry,
  output tpw_entry_t rd_entry,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tpw_entry_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/testport_writer.sv
// Frames a valid/ready payload stream onto the data-memory write bus toward the
// TestPort checker: BEGIN_SYM, payload words, END_SYM, one wen-low cycle between writes.
module testport_writer
  import tp_pkg::*;
#(
  parameter logic [29:0] TEST_PORT  = TP_TEST_PORT,
  parameter logic [31:0] BEGIN_SYM  = TP_BEGIN_SYM,
  parameter logic [31:0] END_SYM    = TP_END_SYM,
  parameter int          MAX_WORDS  = TP_MAX_WORDS,
  parameter int          FIFO_DEPTH = TP_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        stall,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        wen,
  output logic        busy,
  output logic        done,
  output logic [6:0]  word_cnt
);

  localparam logic [6:0] CNT_MAX = 7'(MAX_WORDS);

  tpw_state_t  state;
  tpw_state_t  state_next;
  tpw_kind_t   kind;
  tpw_kind_t   kind_next;
  tpw_entry_t  cur;
  tpw_entry_t  cur_next;
  tpw_entry_t  fifo_rd;
  tpw_entry_t  fifo_wr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic [6:0]  cnt_next;
  logic        done_next;
  logic        wen_next;
  logic        busy_next;
  logic [31:0] word_sel;

  assign fifo_wr  = '{last: in_last, word: in_data};
  assign in_ready = !fifo_full;

  tpw_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pop      (pop),
    .wr_entry (fifo_wr),
    .rd_entry (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_next = state;
    kind_next  = kind;
    cur_next   = cur;
    cnt_next   = word_cnt;
    done_next  = done;
    pop        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = WR_BEGIN;
          cnt_next   = '0;
          done_next  = 1'b0;
        end
      end
      WR_BEGIN: begin
        if (!stall) begin
          state_next = GAP;
          kind_next  = KIND_DATA;
        end
      end
      GAP: begin
        if (kind == KIND_END) begin
          state_next = WR_END;
        end else if (!fifo_empty) begin
          // The entry is captured at pop time so a stall can never lose it.
          state_next = WR_DATA;
          pop        = 1'b1;
          cur_next   = fifo_rd;
        end
      end
      WR_DATA: begin
        if (!stall) begin
          state_next = GAP;
          if (word_cnt < CNT_MAX) cnt_next = word_cnt + 7'd1;
          kind_next = (cur.last || (word_cnt + 7'd1 == CNT_MAX)) ? KIND_END : KIND_DATA;
        end
      end
      WR_END: begin
        if (!stall) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they can be registered.
  always_comb begin
    word_sel = '0;
    wen_next = 1'b0;
    case (state_next)
      WR_BEGIN: begin word_sel = BEGIN_SYM;     wen_next = 1'b1; end
      WR_DATA:  begin word_sel = cur_next.word; wen_next = 1'b1; end
      WR_END:   begin word_sel = END_SYM;       wen_next = 1'b1; end
      default:  begin word_sel = '0;            wen_next = 1'b0; end
    endcase
    busy_next = (state_next != IDLE) && (state_next != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      kind     <= KIND_DATA;
      cur      <= '0;
      word_cnt <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      wen      <= 1'b0;
      addr     <= '0;
      data     <= '0;
    end else begin
      state    <= state_next;
      kind     <= kind_next;
      cur      <= cur_next;
      word_cnt <= cnt_next;
      done     <= done_next;
      busy     <= busy_next;
      wen      <= wen_next;
      addr     <= wen_next ? TEST_PORT : '0;
      data     <= wen_next ? byte_swap(word_sel) : '0;
    end
  end

endmodule
